// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_port_arbiter shared definitions.
// FSM encoding and sizing constants for the two-client port arbiter.
package sdram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam int N_CLIENTS    = 2;
    localparam int CLIENT_W     = 1;

endpackage

// File: rtl/sdram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// Lone requester wins; on a tie the client that did not go last wins.
module sdram_port_arbiter_rr_pick2
    import sdram_port_arbiter_pkg::*;
(
    input  logic [1:0]          elig,
    input  logic [CLIENT_W-1:0] rr_last,
    output logic [1:0]          sel,
    output logic                valid
);

    // one-hot selection from the eligible vector and last winner
    always_comb begin
        sel = 2'b00;
        unique case (elig)
            2'b01:   sel = 2'b01;
            2'b10:   sel = 2'b10;
            2'b11:   sel = rr_last[0] ? 2'b01 : 2'b10;
            default: sel = 2'b00;
        endcase
    end

    assign valid = |elig;

endmodule

// File: rtl/sdram_port_arbiter.sv
// SDRAM FIFO port arbiter between two burst clients.
// One fixed-length burst per grant, round-robin, with a 2-cycle drain.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 128,
    parameter int CNT_W     = 8
)
(
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [1:0]        iREQ,
    input  logic [1:0]        iREQ_WR,
    input  logic [DATA_W-1:0] iWDATA0,
    input  logic [DATA_W-1:0] iWDATA1,
    output logic [1:0]        oGNT,
    output logic [1:0]        oPULL,
    output logic [DATA_W-1:0] oRDATA,
    output logic [1:0]        oRVALID,
    output logic              oBUSY,
    output logic              oWR,
    output logic [DATA_W-1:0] oWRDATA,
    input  logic              iWR_ROOM,
    output logic              oRD,
    input  logic [DATA_W-1:0] iRDDATA,
    input  logic              iRD_READY
);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CLIENT_W-1:0] cli;
    logic [CLIENT_W-1:0] rr_last;
    logic                dir_wr;
    logic [1:0]          elig;
    logic [1:0]          pick;
    logic                pick_v;
    logic                last_xfer;
    logic                last_drain;
    logic                wr_now;
    logic                rd_d1;

    // a client is eligible only if its FIFO side can take a whole burst
    always_comb begin
        elig = 2'b00;
        for (int i = 0; i < N_CLIENTS; i++) begin
            elig[i] = iREQ[i] &
                      ((iREQ_WR[i] & iWR_ROOM) |
                       (~iREQ_WR[i] & iRD_READY));
        end
    end

    sdram_port_arbiter_rr_pick2 u_pick (
        .elig    (elig),
        .rr_last (rr_last),
        .sel     (pick),
        .valid   (pick_v)
    );

    assign last_xfer  = (cnt == CNT_W'(BURST_LEN - 1));
    assign last_drain = (cnt == CNT_W'(DRAIN_CYCLES - 1));
    assign wr_now     = (state == XFER) && dir_wr;

    // next-state and combinational outputs
    always_comb begin
        state_nxt = state;
        oPULL     = 2'b00;
        oBUSY     = (state != IDLE);
        unique case (state)
            IDLE:  if (pick_v) state_nxt = SETUP;
            SETUP: state_nxt = XFER;
            XFER:  if (last_xfer) state_nxt = DRAIN;
            DRAIN: if (last_drain) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wr_now) oPULL = oGNT;
    end

    // state register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // grant context: latched at selection, released at drain exit
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oGNT    <= 2'b00;
            cli     <= '0;
            dir_wr  <= 1'b0;
            rr_last <= CLIENT_W'(1);
        end else if (state == IDLE && pick_v) begin
            oGNT   <= pick;
            cli    <= CLIENT_W'(pick[1]);
            dir_wr <= pick[1] ? iREQ_WR[1] : iREQ_WR[0];
        end else if (state == DRAIN && last_drain) begin
            oGNT    <= 2'b00;
            rr_last <= cli;
        end
    end

    // burst counter, reused to time the drain
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cnt <= '0;
        end else begin
            unique case (state)
                SETUP:   cnt <= '0;
                XFER:    cnt <= last_xfer ? '0 : cnt + CNT_W'(1);
                DRAIN:   cnt <= cnt + CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // write path: word pulled this cycle is written next cycle
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oWR     <= 1'b0;
            oWRDATA <= '0;
        end else begin
            oWR     <= wr_now;
            oWRDATA <= wr_now ? (cli[0] ? iWDATA1 : iWDATA0) : '0;
        end
    end

    // read path: strobe covers XFER, data returns two cycles later
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oRD     <= 1'b0;
            rd_d1   <= 1'b0;
            oRVALID <= 2'b00;
            oRDATA  <= '0;
        end else begin
            oRD     <= (state_nxt == XFER) && !dir_wr;
            rd_d1   <= oRD;
            oRVALID <= rd_d1 ? oGNT : 2'b00;
            oRDATA  <= rd_d1 ? iRDDATA : '0;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter.
// Burst-offset reference model plus directed and random stimulus.
module tb_sdram_port_arbiter;

    localparam int DW = 16;
    localparam int BL = 128;
    localparam int CW = 8;
    localparam int LAST_K = BL + 3;

    logic          iCLK = 1'b0;
    logic          iRST_n;
    logic [1:0]    iREQ;
    logic [1:0]    iREQ_WR;
    logic [DW-1:0] iWDATA0;
    logic [DW-1:0] iWDATA1;
    logic [1:0]    oGNT;
    logic [1:0]    oPULL;
    logic [DW-1:0] oRDATA;
    logic [1:0]    oRVALID;
    logic          oBUSY;
    logic          oWR;
    logic [DW-1:0] oWRDATA;
    logic          iWR_ROOM;
    logic          oRD;
    logic [DW-1:0] iRDDATA;
    logic          iRD_READY;

    always #5 iCLK = ~iCLK;

    sdram_port_arbiter #(
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .CNT_W     (CW)
    ) dut (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iREQ      (iREQ),
        .iREQ_WR   (iREQ_WR),
        .iWDATA0   (iWDATA0),
        .iWDATA1   (iWDATA1),
        .oGNT      (oGNT),
        .oPULL     (oPULL),
        .oRDATA    (oRDATA),
        .oRVALID   (oRVALID),
        .oBUSY     (oBUSY),
        .oWR       (oWR),
        .oWRDATA   (oWRDATA),
        .iWR_ROOM  (iWR_ROOM),
        .oRD       (oRD),
        .iRDDATA   (iRDDATA),
        .iRD_READY (iRD_READY)
    );

    int checks = 0;
    int errors = 0;

    logic       s_rst;
    logic [1:0] s_req;
    logic [1:0] s_req_wr;
    logic       s_room;
    logic       s_rdy;

    logic [15:0] wcnt0;
    logic [15:0] wcnt1;

    // model: mk = cycles since the grant decision, 0 = idle
    int          mk;
    int          mc;
    bit          mwr;
    int          mrr;
    logic [15:0] prev_wd;
    logic [15:0] prev_rd;
    int          words;
    int          last_words;

    logic [1:0]  prev_gnt;
    logic [1:0]  gnt_log[$];
    logic [15:0] wr_log[$];
    bit          log_wr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h want %0h @%0t",
                         nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mk    = 0;
        mrr   = 1;
        words = 0;
    endtask

    task automatic compare_cycle();
        logic [1:0] oh;
        logic [1:0] e_gnt;
        logic [1:0] e_pull;
        logic [1:0] e_rv;
        logic [1:0] el;
        bit act;
        bit e_wr;
        bit e_rd;
        if (!iRST_n) begin
            chk("rst_ctl", 32'({oGNT, oPULL, oRVALID, oBUSY, oWR, oRD}), 0);
            chk("rst_data", 32'({oWRDATA, oRDATA}), 0);
            model_reset();
            prev_gnt = 2'b00;
            return;
        end
        act    = (mk >= 1) && (mk <= LAST_K);
        oh     = (mc == 0) ? 2'b01 : 2'b10;
        e_gnt  = act ? oh : 2'b00;
        e_pull = (act && mwr && mk >= 2 && mk <= BL + 1) ? oh : 2'b00;
        e_wr   = act && mwr && mk >= 3 && mk <= BL + 2;
        e_rd   = act && !mwr && mk >= 2 && mk <= BL + 1;
        e_rv   = (act && !mwr && mk >= 4) ? oh : 2'b00;
        chk("gnt", 32'(oGNT), 32'(e_gnt));
        chk("busy", 32'(oBUSY), 32'(act));
        chk("pull", 32'(oPULL), 32'(e_pull));
        chk("wr", 32'(oWR), 32'(e_wr));
        chk("rd", 32'(oRD), 32'(e_rd));
        chk("rvalid", 32'(oRVALID), 32'(e_rv));
        if (e_wr) chk("wrdata", 32'(oWRDATA), 32'(prev_wd));
        if (e_rv != 0) chk("rdata", 32'(oRDATA), 32'(prev_rd));
        chk("wr_rd_excl", 32'(oWR & oRD), 0);
        chk("gnt_2hot", 32'(oGNT == 2'b11), 0);
        if (oWR) words++;
        if (oRVALID != 0) words++;
        if (log_wr && oWR) wr_log.push_back(oWRDATA);
        if (oGNT != 0 && prev_gnt == 0) gnt_log.push_back(oGNT);
        prev_gnt = oGNT;
        prev_wd  = (mc == 0) ? iWDATA0 : iWDATA1;
        prev_rd  = iRDDATA;
        if (act) begin
            if (mk == LAST_K) begin
                chk("burst_words", 32'(words), BL);
                last_words = words;
            end
            mk++;
            if (mk == LAST_K + 1) begin
                mrr = mc;
                mk  = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++)
                el[c] = iREQ[c] && (iREQ_WR[c] ? iWR_ROOM : iRD_READY);
            if (el != 2'b00) begin
                if (el == 2'b11) mc = (mrr == 1) ? 0 : 1;
                else             mc = el[1] ? 1 : 0;
                mwr   = iREQ_WR[mc];
                words = 0;
                mk    = 1;
            end
        end
        if (oPULL[0]) wcnt0++;
        if (oPULL[1]) wcnt1++;
    endtask

    task automatic step();
        @(negedge iCLK);
        iRST_n    = s_rst;
        iREQ      = s_req;
        iREQ_WR   = s_req_wr;
        iWR_ROOM  = s_room;
        iRD_READY = s_rdy;
        iRDDATA   = 16'($urandom);
        iWDATA0   = wcnt0;
        iWDATA1   = wcnt1 ^ 16'hA500;
        #1;
        compare_cycle();
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int i = 0; i < budget && gnt_log.size() < n; i++) step();
        chk("grant_wait", 32'(gnt_log.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (mk != 0 || oBUSY); i++) step();
        chk("idle_wait", 32'(oBUSY), 0);
    endtask

    task automatic wait_mk(input int k, input int budget);
        for (int i = 0; i < budget && mk != k; i++) step();
        chk("mk_wait", 32'(oBUSY), 1);
    endtask

    initial begin
        int bad;
        s_rst = 0; s_req = 0; s_req_wr = 0; s_room = 0; s_rdy = 0;
        wcnt0 = 0; wcnt1 = 0;
        iRST_n = 0; iREQ = 0; iREQ_WR = 0; iWR_ROOM = 0; iRD_READY = 0;
        iRDDATA = 0; iWDATA0 = 0; iWDATA1 = 0;
        prev_gnt = 0; prev_wd = 0; prev_rd = 0;
        mc = 0; mwr = 0; last_words = 0; log_wr = 0;
        model_reset();
        step();
        step();
        chk("reset_gnt", 32'(oGNT), 0);
        chk("reset_busy", 32'(oBUSY), 0);
        s_rst = 1;
        step();

        // single write burst with ramp data
        wcnt0 = 0; log_wr = 1; gnt_log.delete();
        s_req = 2'b01; s_req_wr = 2'b01; s_room = 1;
        wait_grants(1, 20);
        s_req = 2'b00;
        wait_idle(200);
        log_wr = 0;
        chk("t1_gnt", 32'(gnt_log[0]), 32'(2'b01));
        chk("t1_len", 32'(wr_log.size()), BL);
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i] != 16'(i)) bad++;
        chk("t1_ramp", 32'(bad), 0);
        chk("t1_words", 32'(last_words), BL);

        // both clients reading: alternate grants from a fresh reset
        s_rst = 0; step(); s_rst = 1; step();
        gnt_log.delete();
        s_req = 2'b11; s_req_wr = 2'b00; s_rdy = 1; s_room = 0;
        wait_grants(4, 700);
        s_req = 2'b00;
        wait_idle(200);
        for (int i = 0; i < 4; i++)
            chk("t2_alt", 32'(gnt_log[i]),
                32'((i % 2 == 0) ? 2'b01 : 2'b10));

        // blocked writer does not stall the reader
        gnt_log.delete();
        s_req = 2'b11; s_req_wr = 2'b01; s_room = 0; s_rdy = 1;
        wait_grants(1, 20);
        s_req = 2'b01;
        wait_idle(200);
        s_room = 1;
        wait_grants(2, 20);
        s_req = 2'b00;
        wait_idle(200);
        chk("t3_first", 32'(gnt_log[0]), 32'(2'b10));
        chk("t3_second", 32'(gnt_log[1]), 32'(2'b01));

        // request dropped at XFER cycle 10
        gnt_log.delete();
        s_req = 2'b01; s_req_wr = 2'b01; s_room = 1;
        wait_grants(1, 20);
        wait_mk(12, 50);
        s_req = 2'b00;
        wait_idle(200);
        chk("t4_words", 32'(last_words), BL);

        // reset during XFER cycle 50, then a tie
        gnt_log.delete();
        s_req = 2'b01; s_req_wr = 2'b00; s_rdy = 1;
        wait_grants(1, 20);
        wait_mk(52, 80);
        s_rst = 0;
        step();
        chk("t5_gnt", 32'(oGNT), 0);
        chk("t5_busy", 32'(oBUSY), 0);
        chk("t5_rd", 32'(oRD), 0);
        step();
        gnt_log.delete();
        s_req = 2'b11; s_req_wr = 2'b00; s_rst = 1;
        wait_grants(1, 20);
        chk("t5_tie", 32'(gnt_log[0]), 32'(2'b01));
        s_req = 2'b00;
        wait_idle(200);

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            s_req    = 2'($urandom);
            s_req_wr = 2'($urandom);
            s_room   = ($urandom_range(0, 3) != 0);
            s_rdy    = ($urandom_range(0, 3) != 0);
            step();
        end
        s_req = 2'b00;
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
